// File: rtl/truth_table_sweeper_if.sv
// Handshake/result bundle between the truth-table sweeper and the gate-under-test harness.
//   start           : request a new sweep (harness -> sweeper)
//   y               : gate output (gate/harness -> sweeper)
//   vec             : gate input vector (sweeper -> gate)
//   busy, done      : sweep progress flags
//   pass            : sweep finished with no mismatches
//   mismatch        : one-cycle pulse after a failing check
//   err_count       : mismatching vectors in current/last sweep
//   first_fail_idx  : vector index of the first mismatch
// The master modport is the sweeper itself; the slave modport is the harness side.
interface truth_table_sweeper_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            y;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic            mismatch;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_idx;

  modport master (
    input  start, y,
    output vec, busy, done, pass, mismatch, err_count, first_fail_idx
  );

  modport slave (
    output start, y,
    input  vec, busy, done, pass, mismatch, err_count, first_fail_idx
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/check block for a small combinational gate.
// Drives every input vector 0..2**N_IN-1 in ascending order, holds each one for
// SETTLE cycles, then samples the gate output for one CHECK cycle and compares it
// with bit vec of EXPECT. Mismatches are counted and the first failing vector is kept.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : truth_table_sweeper_if.master (start/y in; vec and status/results out)
module truth_table_sweeper #(
  parameter int                     N_IN   = 2,
  parameter int                     SETTLE = 1,
  parameter logic [(2**N_IN)-1:0]   EXPECT = 4'b1000
) (
  input  logic                   clk,
  input  logic                   rst,
  truth_table_sweeper_if.master  bus
);

  localparam int              NVEC     = 2**N_IN;
  localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_IN-1:0] vec_q;
  logic [N_IN:0]   err_q;
  logic [N_IN-1:0] ffi_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic            mm_q;

  // Gate output disagrees with the expected truth-table bit for the current vector.
  logic miss;
  assign miss = (bus.y != EXPECT[vec_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mm_q    <= 1'b0;
    end else begin
      // mismatch is a single-cycle pulse; only CHECK can raise it.
      mm_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            vec_q   <= '0;
            err_q   <= '0;
            ffi_q   <= '0;
            cnt_q   <= CNT_LOAD;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_CHECK: begin
          if (miss) begin
            mm_q  <= 1'b1;
            err_q <= err_q + 1'b1;
            if (err_q == '0) begin
              ffi_q <= vec_q;
            end
          end
          if (vec_q == LAST_VEC) begin
            // vec keeps the last index; pass must include this final comparison.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= !miss && (err_q == '0);
            state_q <= S_DONE;
          end else begin
            vec_q   <= vec_q + 1'b1;
            cnt_q   <= CNT_LOAD;
            state_q <= S_SETTLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec            = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.mismatch       = mm_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a default AND2 configuration driven by a
// selectable gate model, plus a 3-input SETTLE=3 instance checked against AND3.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   mode     = 0;   // 0: and, 1: or, 2: stuck at 0

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(2)) a ();
  truth_table_sweeper_if #(.N_IN(3)) b ();

  assign a.y = (mode == 0) ? (&a.vec) : (mode == 1) ? (|a.vec) : 1'b0;
  assign b.y = &b.vec;

  truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECT(4'b1000)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(3), .EXPECT(8'h80)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, ".vec"},  32'(a.vec), 0);
    chk({tag, ".busy"}, 32'(a.busy), 0);
    chk({tag, ".done"}, 32'(a.done), 0);
    chk({tag, ".pass"}, 32'(a.pass), 0);
    chk({tag, ".mm"},   32'(a.mismatch), 0);
    chk({tag, ".err"},  32'(a.err_count), 0);
    chk({tag, ".ffi"},  32'(a.first_fail_idx), 0);
  endtask

  // Full sweep on the default instance. Edge 1 captures start; vector v is checked in
  // the cycle before edge 2v+3, so its mismatch pulse is visible after that edge.
  task automatic run_a(input string tag, input logic [3:0] fail_mask,
                       input int exp_err, input int exp_ffi, input bit repulse);
    int exp_vec;
    logic exp_mm;
    a.start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      a.start = repulse && (k == 5);
      exp_vec = (k <= 8) ? (k - 1) / 2 : 3;
      exp_mm  = (k >= 3) && (k % 2 == 1) && fail_mask[(k - 3) / 2];
      chk($sformatf("%s.vec@%0d", tag, k),  32'(a.vec), 32'(exp_vec));
      chk($sformatf("%s.busy@%0d", tag, k), 32'(a.busy), 32'(k <= 8));
      chk($sformatf("%s.done@%0d", tag, k), 32'(a.done), 32'(k == 9));
      chk($sformatf("%s.mm@%0d", tag, k),   32'(a.mismatch), 32'(exp_mm));
    end
    chk({tag, ".err"},  32'(a.err_count), 32'(exp_err));
    chk({tag, ".ffi"},  32'(a.first_fail_idx), 32'(exp_ffi));
    chk({tag, ".pass"}, 32'(a.pass), 32'(exp_err == 0));
  endtask

  initial begin
    a.start = 1'b0;
    b.start = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk_idle_a("rst0");
    chk("rst0.b_done", 32'(b.done), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_idle_a("idle");

    // Correct AND2 gate.
    mode = 0;
    run_a("and", 4'b0000, 0, 0, 1'b0);

    // DONE holds with start low, and y activity outside CHECK is ignored.
    mode = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold.done@%0d", k), 32'(a.done), 1);
      chk($sformatf("hold.pass@%0d", k), 32'(a.pass), 1);
      chk($sformatf("hold.vec@%0d", k),  32'(a.vec), 3);
      chk($sformatf("hold.err@%0d", k),  32'(a.err_count), 0);
    end

    // Wrong gate (OR): vectors 1 and 2 fail. Restart from DONE.
    run_a("or", 4'b0110, 2, 1, 1'b0);

    // Stuck-at-0: only vector 3 fails, pulse coincides with done.
    mode = 2;
    run_a("stuck0", 4'b1000, 1, 3, 1'b0);

    // start re-pulsed while busy at vec=2 is ignored.
    mode = 0;
    run_a("repulse", 4'b0000, 0, 0, 1'b1);

    // Asynchronous reset mid-SETTLE at vec=1.
    mode = 2;
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    tick();
    tick();
    chk("midrst.pre_vec",  32'(a.vec), 1);
    chk("midrst.pre_busy", 32'(a.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk_idle_a("midrst");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle_a($sformatf("post%0d", k));
    end

    // 3-input gate, SETTLE=3: 8 vectors x 4 cycles, done at edge 33.
    b.start = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      tick();
      b.start = 1'b0;
      chk($sformatf("b.vec@%0d", k),  32'(b.vec), 32'((k <= 32) ? (k - 1) / 4 : 7));
      chk($sformatf("b.done@%0d", k), 32'(b.done), 32'(k == 33));
      chk($sformatf("b.mm@%0d", k),   32'(b.mismatch), 0);
    end
    chk("b.pass", 32'(b.pass), 1);
    chk("b.err",  32'(b.err_count), 0);
    chk("b.busy", 32'(b.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
